// File: rtl/video_pkg.sv
// video_pkg: pixel types and video constants shared by the framebuffer and the composite encoder.
package video_pkg;
  typedef struct packed { logic [7:0] y; logic [7:0] cb; logic [7:0] cr; } ycbcr_t;
  typedef struct packed { logic [7:0] r; logic [7:0] g; logic [7:0] b; } rgb_t;

  typedef logic [9:0] phase_t;
  localparam phase_t PHASE_90  = 10'd256;
  localparam phase_t PHASE_180 = 10'd512;

  localparam logic [7:0] COMPOSITE_REG_PAGE = 8'h04;

  typedef struct packed {
    logic [31:0] phase_inc;
    logic [7:0]  burst_start;
    logic [7:0]  burst_len;
    logic [7:0]  burst_amp;
    logic        chroma_en;
    logic        frame_phase_reset;
  } comp_regs_t;

  localparam longint SINE_PI_Q30 = 64'sd3373259426;

  // Elaboration-time sine: quarter-wave Taylor series in Q30, rounded to +/-127.
  function automatic logic signed [7:0] sine_q8(input int idx);
    longint x, x2, term, acc, r, d;
    int k, quad;
    logic signed [7:0] res;
    quad = (idx / 256) % 4;
    k    = idx % 256;
    if ((quad % 2) == 1) k = 256 - k;
    x    = (longint'(k) * SINE_PI_Q30) / 64'sd512;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 8; n++) begin
      d    = longint'((2 * n) * (2 * n + 1));
      term = -(((term * x2) >>> 30) / d);
      acc  = acc + term;
    end
    r = (64'sd127 * acc + (64'sd1 <<< 29)) >>> 30;
    if (quad >= 2) r = -r;
    res = r[7:0];
    return res;
  endfunction
endpackage

// File: rtl/debug_bus_if.sv
// debug_bus_if: byte-wide register write bus from the debug controller.
interface debug_bus_if;
  logic        write_enable;
  logic [15:0] addr;
  logic [7:0]  wdata;

  modport master (output write_enable, addr, wdata);
  modport slave  (input  write_enable, addr, wdata);
endinterface

// File: rtl/sine_lut.sv
// sine_lut: 1024-entry signed full-sine ROM, three registered read ports (sin, cos, burst).
module sine_lut
  import video_pkg::*;
(
  input  logic              clk,
  input  phase_t            sin_addr,
  input  phase_t            cos_addr,
  input  phase_t            burst_addr,
  output logic signed [7:0] sin_q,
  output logic signed [7:0] cos_q,
  output logic signed [7:0] burst_q
);
  logic signed [7:0] rom [1024];

  for (genvar i = 0; i < 1024; i++) begin : g_rom
    localparam logic signed [7:0] V = sine_q8(i);
    assign rom[i] = V;
  end

  always_ff @(posedge clk) begin
    sin_q   <= rom[sin_addr];
    cos_q   <= rom[cos_addr];
    burst_q <= rom[burst_addr];
  end
endmodule

// File: rtl/composite_encoder.sv
// composite_encoder: Y/Cb/Cr pixels to an 8-bit composite DAC code (subcarrier, burst, sync, blank).
// Define COMPOSITE_ENCODER_PAL_EN for PAL line-alternating V phase; the default build is NTSC.
module composite_encoder
  import video_pkg::*;
#(
  parameter logic [7:0]  SYNC_LEVEL      = 8'd0,
  parameter logic [7:0]  BLANK_LEVEL     = 8'd56,
  parameter logic [7:0]  LUMA_GAIN       = 8'd170,
  parameter logic [31:0] PHASE_INC_RESET = 32'd396713482,
  parameter logic [7:0]  REG_PAGE        = COMPOSITE_REG_PAGE
) (
  input  logic        clk,
  input  logic        rst_n,
  debug_bus_if.slave  dbus,
  input  ycbcr_t      in,
  input  logic        newline,
  input  logic        newframe,
  input  logic        sync,
  input  logic        blank,
  input  logic [12:0] video_x,
  output logic [7:0]  dac_out
);
  comp_regs_t  regs;
  logic [31:0] phase_acc;
  logic        v_sign;
  phase_t      phase, cos_phase, burst_phase, burst_addr;
  logic [12:0] gate_lo, gate_hi;
  logic        burst_gate;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs.phase_inc         <= PHASE_INC_RESET;
      regs.burst_start       <= 8'd19;
      regs.burst_len         <= 8'd108;
      regs.burst_amp         <= 8'd40;
      regs.chroma_en         <= 1'b1;
      regs.frame_phase_reset <= 1'b0;
    end else if (dbus.write_enable && dbus.addr[15:8] == REG_PAGE) begin
      case (dbus.addr[7:0])
        8'd0: regs.phase_inc[31:24] <= dbus.wdata;
        8'd1: regs.phase_inc[23:16] <= dbus.wdata;
        8'd2: regs.phase_inc[15:8]  <= dbus.wdata;
        8'd3: regs.phase_inc[7:0]   <= dbus.wdata;
        8'd4: regs.burst_start      <= dbus.wdata;
        8'd5: regs.burst_len        <= dbus.wdata;
        8'd6: regs.burst_amp        <= dbus.wdata;
        8'd7: begin
          regs.chroma_en         <= dbus.wdata[0];
          regs.frame_phase_reset <= dbus.wdata[1];
        end
        default: ;
      endcase
    end
  end

  // Accumulator wraps modulo 2^32 on purpose; frame reset wins over the increment.
  always_ff @(posedge clk) begin
    if (!rst_n)                                     phase_acc <= '0;
    else if (regs.frame_phase_reset && newframe)    phase_acc <= '0;
    else                                            phase_acc <= phase_acc + regs.phase_inc;
  end

`ifdef COMPOSITE_ENCODER_PAL_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                     v_sign <= 1'b0;
    else if (regs.frame_phase_reset && newframe)    v_sign <= 1'b0;
    else if (newline)                               v_sign <= ~v_sign;
  end
  assign burst_phase = v_sign ? 10'd640 : 10'd384;
`else
  assign v_sign      = 1'b0;
  assign burst_phase = PHASE_180;
`endif

  assign phase      = phase_acc[31:22];
  assign cos_phase  = phase + PHASE_90;
  assign burst_addr = phase + burst_phase;

  assign gate_lo    = {3'b000, regs.burst_start, 2'b00};
  assign gate_hi    = gate_lo + {5'b00000, regs.burst_len};
  assign burst_gate = (video_x >= gate_lo) && (video_x < gate_hi);

  logic signed [7:0] sin_q, cos_q, burst_q;

  sine_lut u_lut (
    .clk       (clk),
    .sin_addr  (phase),
    .cos_addr  (cos_phase),
    .burst_addr(burst_addr),
    .sin_q     (sin_q),
    .cos_q     (cos_q),
    .burst_q   (burst_q)
  );

  function automatic logic signed [7:0] sat_s8(input logic [7:0] c);
    logic signed [8:0] d;
    d = $signed({1'b0, c}) - 9'sd128;
    if (d > 9'sd127)       return 8'sd127;
    else if (d < -9'sd128) return -8'sd128;
    else                   return d[7:0];
  endfunction

  // S1: centred chroma, luma and control ride alongside the registered LUT read.
  logic signed [7:0] s1_u, s1_v;
  logic [7:0]        s1_y;
  logic              s1_sync, s1_blank, s1_gate, s1_vneg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_u <= '0; s1_v <= '0; s1_y <= '0;
      s1_sync <= 1'b0; s1_blank <= 1'b1; s1_gate <= 1'b0; s1_vneg <= 1'b0;
    end else begin
      s1_u     <= sat_s8(in.cb);
      s1_v     <= sat_s8(in.cr);
      s1_y     <= in.y;
      s1_sync  <= sync;
      s1_blank <= blank;
      s1_gate  <= burst_gate;
      s1_vneg  <= v_sign;
    end
  end

  // S2: quadrature modulation, luma gain and burst amplitude.
  logic signed [17:0] us, vc, csum, bprod;
  logic [15:0]        lprod;

  always_comb begin
    us    = 18'(s1_u) * 18'(sin_q);
    vc    = 18'(s1_v) * 18'(cos_q);
    if (s1_vneg) vc = -vc;
    csum  = us + vc;
    lprod = s1_y * LUMA_GAIN;
    bprod = $signed({10'b0, regs.burst_amp}) * 18'(burst_q);
  end

  logic signed [9:0] s2_chroma, s2_burst;
  logic [7:0]        s2_luma;
  logic              s2_sync, s2_blank, s2_gate;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_chroma <= '0; s2_burst <= '0; s2_luma <= '0;
      s2_sync <= 1'b0; s2_blank <= 1'b1; s2_gate <= 1'b0;
    end else begin
      s2_chroma <= csum[17:8];
      s2_burst  <= bprod[16:7];
      s2_luma   <= lprod[15:8];
      s2_sync   <= s1_sync;
      s2_blank  <= s1_blank;
      s2_gate   <= s1_gate;
    end
  end

  // S3: level select and clamp.
  logic signed [10:0] sum;
  logic [7:0]         level;

  always_comb begin
    if (s2_blank && s2_gate)
      sum = $signed({3'b000, BLANK_LEVEL}) + 11'(s2_burst);
    else if (s2_blank)
      sum = $signed({3'b000, BLANK_LEVEL});
    else
      sum = $signed({3'b000, BLANK_LEVEL}) + $signed({3'b000, s2_luma})
          + (regs.chroma_en ? 11'(s2_chroma) : 11'sd0);
    if (sum < 11'sd0)        level = 8'd0;
    else if (sum > 11'sd255) level = 8'd255;
    else                     level = sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       dac_out <= BLANK_LEVEL;
    else if (s2_sync) dac_out <= SYNC_LEVEL;
    else              dac_out <= level;
  end
endmodule

// File: tb/tb_composite_encoder.sv
// tb_composite_encoder: randomized stimulus checked against a real-arithmetic reference model.
module tb_composite_encoder;
  import video_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  ycbcr_t      pix;
  logic        newline, newframe, sync, blank;
  logic [12:0] video_x;
  logic [7:0]  dac_out;

  debug_bus_if dbus();

  composite_encoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dbus    (dbus),
    .in      (pix),
    .newline (newline),
    .newframe(newframe),
    .sync    (sync),
    .blank   (blank),
    .video_x (video_x),
    .dac_out (dac_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  bit [31:0] m_phase, m_inc;
  int        m_bstart, m_blen, m_amp;
  bit        m_cen, m_fpr, m_vs;
  int        pipe [3];

  localparam real PI = 3.14159265358979323846;

  function automatic int sinr(input int p);
    real a;
    a = 2.0 * PI * real'(p % 1024) / 1024.0;
    return int'($floor(127.0 * $sin(a) + 0.5));
  endfunction

  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int clamp(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int model_out();
    int ph, bp, u, v, c, x;
    ph = int'(m_phase[31:22]);
`ifdef COMPOSITE_ENCODER_PAL_EN
    bp = m_vs ? 640 : 384;
`else
    bp = 512;
`endif
    x = int'(video_x);
    if (sync) return 0;
    if (blank && x >= m_bstart * 4 && x < m_bstart * 4 + m_blen)
      return clamp(56 + fdiv(m_amp * sinr(ph + bp), 128));
    if (blank) return 56;
    u = int'(pix.cb) - 128;
    v = int'(pix.cr) - 128;
    c = fdiv(u * sinr(ph) + (m_vs ? -1 : 1) * v * sinr(ph + 256), 256);
    return clamp(56 + (int'(pix.y) * 170) / 256 + (m_cen ? c : 0));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_vs = 0; m_inc = 32'd396713482;
    m_bstart = 19; m_blen = 108; m_amp = 40; m_cen = 1; m_fpr = 0;
    pipe = '{56, 56, 56};
  endtask

  task automatic tick();
    int e;
    e = model_out();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
`ifdef COMPOSITE_ENCODER_PAL_EN
      if (m_fpr && newframe) m_vs = 0;
      else if (newline)      m_vs = !m_vs;
`endif
      if (m_fpr && newframe) m_phase = 0;
      else                   m_phase = m_phase + m_inc;
      if (dbus.write_enable && dbus.addr[15:8] == 8'h04) begin
        case (dbus.addr[7:0])
          8'd0: m_inc[31:24] = dbus.wdata;
          8'd1: m_inc[23:16] = dbus.wdata;
          8'd2: m_inc[15:8]  = dbus.wdata;
          8'd3: m_inc[7:0]   = dbus.wdata;
          8'd4: m_bstart     = int'(dbus.wdata);
          8'd5: m_blen       = int'(dbus.wdata);
          8'd6: m_amp        = int'(dbus.wdata);
          8'd7: begin m_cen = dbus.wdata[0]; m_fpr = dbus.wdata[1]; end
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic wr(input logic [7:0] page, input logic [7:0] a, input logic [7:0] d);
    dbus.write_enable = 1'b1; dbus.addr = {page, a}; dbus.wdata = d;
    tick();
    dbus.write_enable = 1'b0;
  endtask

  task automatic set_inc(input logic [31:0] inc);
    wr(8'h04, 8'd0, inc[31:24]); wr(8'h04, 8'd1, inc[23:16]);
    wr(8'h04, 8'd2, inc[15:8]);  wr(8'h04, 8'd3, inc[7:0]);
  endtask

  int pk, dv;
  int outv [10];

  initial begin
    dbus.write_enable = 1'b0; dbus.addr = '0; dbus.wdata = '0;
    rst_n = 1'b0; sync = 0; blank = 0; newline = 0; newframe = 0; video_x = '0;
    pix.y = 8'd255; pix.cb = 8'd128; pix.cr = 8'd128;

    // Reset holds blank level, then y=255 emerges after the pipeline fills
    tick(); chk("rst_c0", dac_out, 56);
    tick(); chk("rst_c1", dac_out, 56);
    rst_n = 1'b1;
    tick(); chk("rel_c0", dac_out, 56);
    tick(); chk("rel_c1", dac_out, 56);
    tick(); chk("rel_y255", dac_out, 225);

    // Grey without chroma
    pix.y = 8'd128;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin tick(); chk("grey", dac_out, 141); end

    // Foreign page and out-of-range address writes are ignored
    wr(8'h05, 8'd7, 8'h00);
    wr(8'h04, 8'd8, 8'h00);
    pix.cr = 8'd255;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin tick(); chk("ign_wr", dac_out, pipe[2]); end
    pix.cr = 8'd128;

    // Sync beats burst gate, then burst-only blanking
    sync = 1; blank = 1; video_x = 13'd100;
    repeat (3) tick();
    chk("sync_prio", dac_out, 0);
    sync = 0;
    repeat (3) tick();
    pk = 0;
    for (int i = 0; i < 64; i++) begin
      tick(); chk("burst", dac_out, pipe[2]);
      dv = int'(dac_out) - 56; if (dv < 0) dv = -dv;
      if (dv > pk) pk = dv;
    end
    chk("burst_peak", (pk >= 38 && pk <= 40), 1);

    // Burst window edges (76 inclusive, 184 exclusive)
    video_x = 13'd75;  repeat (3) tick(); chk("gate_pre",  dac_out, 56);
    video_x = 13'd184; repeat (3) tick(); chk("gate_post", dac_out, 56);
    video_x = 13'd76;  repeat (3) tick(); chk("gate_in",   dac_out, pipe[2]);

    // Saturation
    blank = 0; pix.y = 8'd255; pix.cb = 8'd128; pix.cr = 8'd255;
    repeat (3) tick();
    for (int i = 0; i < 40; i++) begin
      tick(); chk("sat", dac_out, pipe[2]);
      chk("sat_nowrap", (dac_out >= 8'd90), 1);
    end

    // NCO quarter-turn steps after frame phase reset
    set_inc(32'h4000_0000);
    wr(8'h04, 8'd6, 8'd128);
    wr(8'h04, 8'd7, 8'h03);
    blank = 1; video_x = 13'd100;
    newframe = 1; tick(); newframe = 0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      tick(); chk("nco", dac_out, pipe[2]);
`ifndef COMPOSITE_ENCODER_PAL_EN
      case (i)
        0: chk("nco_0",   dac_out, 56);
        1: chk("nco_90",  dac_out, 0);
        2: chk("nco_180", dac_out, 56);
        default: chk("nco_270", dac_out, 183);
      endcase
`endif
    end

    // Two consecutive lines at identical subcarrier phase
    blank = 0; pix.y = 8'd128; pix.cb = 8'd128; pix.cr = 8'd200;
    newframe = 1; tick(); newframe = 0;
    for (int t = 0; t < 10; t++) begin
      newline = (t == 3);
      tick();
      newline = 0;
      outv[t] = int'(dac_out);
      chk("lines", dac_out, pipe[2]);
    end
    for (int t = 0; t < 4; t++) begin
`ifdef COMPOSITE_ENCODER_PAL_EN
      chk("pal_inv", ((outv[t+2] - 141) + (outv[t+6] - 141)) inside {-1, 0, 1}, 1);
`else
      chk("ntsc_same", outv[t+2], outv[t+6]);
`endif
    end

    // Random registers and stimulus
    for (int r = 0; r < 3; r++) begin
      set_inc($urandom);
      wr(8'h04, 8'd4, 8'($urandom_range(0, 60)));
      wr(8'h04, 8'd5, 8'($urandom));
      wr(8'h04, 8'd6, 8'($urandom));
      wr(8'h04, 8'd7, 8'($urandom_range(0, 3)));
      repeat (3) tick();
      for (int i = 0; i < 200; i++) begin
        pix.y = 8'($urandom); pix.cb = 8'($urandom); pix.cr = 8'($urandom);
        newline  = ($urandom_range(0, 15) == 0);
        newframe = !newline && ($urandom_range(0, 31) == 0);
        sync     = ($urandom_range(0, 7) == 0);
        blank    = sync || ($urandom_range(0, 2) == 0);
        video_x  = 13'($urandom_range(0, 400));
        tick();
        chk("rand", dac_out, pipe[2]);
      end
      newline = 0; newframe = 0;
    end

    // Reset mid-line forces blank on the next cycle
    sync = 0; blank = 0; pix.y = 8'd255;
    repeat (3) tick();
    rst_n = 1'b0; tick(); chk("midline_rst", dac_out, 56);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
